token_event_logger: RTL
=======================

# token_event_logger

Downstream stage of the tick-tock-tokens event processor core. Captures the single-cycle `token_start` / `token_end` pulses it emits, tags each with a timestamp from a free-running cycle counter, and buffers the tagged events in a small FIFO. The FIFO drains over a valid/ready interface toward the readout logic. Dropped events are counted, never silently lost.

## Interface
- `TS_BITS`, 8: timestamp width; counter wraps modulo 2^TS_BITS.
- `DEPTH_BITS`, 2: FIFO holds 2^DEPTH_BITS entries.
- `clk` in 1: single clock; all logic on posedge.
- `rst_n` in 1: synchronous, active-low reset.
- `token_start` in 1: start pulse from the core.
- `token_end` in 1: end pulse from the core.
- `evt_valid` out 1: head entry available.
- `evt_ready` in 1: consumer accepts the head entry when `evt_valid && evt_ready` at posedge.
- `evt_kind` out 2: head entry kind. 01 = start, 10 = end, 11 = collision (both pulses in the same cycle).
- `evt_time` out TS_BITS: head entry timestamp.
- `evt_count` out DEPTH_BITS+1: current occupancy, 0..2^DEPTH_BITS.
- `overflow` out 1: sticky flag, set on the first dropped event.
- `drop_count` out 8: number of dropped events, saturating at 255.

## Operation
- Timestamp counter `ts` increments by 1 every cycle and wraps from 2^TS_BITS−1 to 0.
- Capture: each cycle, if `token_start || token_end`, form one entry with kind {`token_end`, `token_start`} and time = `ts` value of that cycle. At most one push per cycle. A collision produces a single entry of kind 11.
- FIFO: circular buffer with one write pointer, one read pointer, and occupancy count; pointers wrap at 2^DEPTH_BITS.
- Pop: occurs when `evt_valid && evt_ready`; the head advances.
- Full with no pop in the same cycle: the push is dropped, `overflow` is set to 1, and `drop_count` increments unless it is already 255. FIFO contents are unchanged.
- Full with a pop in the same cycle: the push is accepted and occupancy stays at 2^DEPTH_BITS.
- Empty with a push in the same cycle: no pop is possible, because `evt_valid` was 0. No bypass path exists.
- Simultaneous push and pop when not full: both occur and occupancy is unchanged.
- `evt_kind` and `evt_time` come from registered head storage. They must hold stable while `evt_valid && !evt_ready`, and are 0 while `evt_valid` is 0.
- `evt_count` equals the number of stored entries; `evt_valid` equals `evt_count != 0`.
- Reset, whether at power-up or mid-operation, clears the FIFO, pointers, `ts`, `overflow`, and `drop_count`. Any entry in flight is discarded.
- Reset values: `evt_valid`=0, `evt_kind`=0, `evt_time`=0, `evt_count`=0, `overflow`=0, `drop_count`=0.

## Timing
- `ts` reads 0 in the first cycle with `rst_n` high; a pulse in that cycle gets time 0.
- Latency: a pulse sampled at posedge N (FIFO empty) gives `evt_valid`=1, with that entry at the head, from posedge N+1.
- Throughput: one push and one pop per cycle sustained.
- `overflow` and `drop_count` update at the same posedge that rejects the push.
- Inputs arriving while `rst_n`=0 are ignored.

## Configuration
- `TOKEN_LOGGER_DELTA_EN` defined: `evt_time` holds the delta, equal to the `ts` of this entry minus the `ts` of the previous accepted entry, modulo 2^TS_BITS.
  - The reference point is the last accepted push, not the last popped entry.
  - Dropped events do not update the reference.
  - The reference is 0 after reset, so the first entry carries its absolute `ts`.
- `TOKEN_LOGGER_DELTA_EN` not defined: `evt_time` holds the absolute `ts`.
- Interface and all other behaviour are identical in both builds.

## Test plan
- Reset release, `token_start` pulse in cycle 3 with `evt_ready`=0 → `evt_valid` rises in cycle 4 with kind 01 and time 3, and holds stable for 10 cycles.
- Default depth 4, `evt_ready`=0, starts at cycles 1,2,3,4,5,6 → `evt_count`=4 and `overflow`=1 from cycle 6, `drop_count`=2. Draining yields times 1,2,3,4.
- FIFO full, `evt_ready`=1 and `token_end` in the same cycle → entry accepted, `evt_count` stays 4, `drop_count` unchanged.
- `token_start` and `token_end` both high in cycle 7 → one entry of kind 11 with time 7.
- `ts` wrap with TS_BITS=8: events at cycles 250 and 260 → absolute build reports 250 and 4; with `TOKEN_LOGGER_DELTA_EN`, reports 250 and 10.
- `rst_n` low for 1 cycle with 3 entries queued and `overflow`=1 → next cycle `evt_valid`=0, `evt_count`=0, `overflow`=0, `drop_count`=0, and `ts` restarts at 0.

Source files
------------

// File: rtl/token_event_logger.sv
// token_event_logger
// Timestamps single-cycle token_start / token_end pulses from the event
// processor core and queues them in a small FIFO drained over valid/ready.
// Events that arrive while the FIFO is full are dropped and counted.
//
// Build option: define TOKEN_LOGGER_DELTA_EN to report evt_time as the delta
// from the previous accepted entry instead of the absolute timestamp.
//
// Ports:
//   clk          clock, all logic on posedge
//   rst_n        synchronous active-low reset
//   token_start  start pulse from the core
//   token_end    end pulse from the core
//   evt_valid    head entry available
//   evt_ready    consumer accepts head when evt_valid && evt_ready
//   evt_kind     head kind: 01 start, 10 end, 11 collision
//   evt_time     head timestamp (absolute or delta)
//   evt_count    FIFO occupancy, 0..2^DEPTH_BITS
//   overflow     sticky, set on the first dropped event
//   drop_count   dropped events, saturating at 255
module token_event_logger #(
    parameter int unsigned TS_BITS    = 8,
    parameter int unsigned DEPTH_BITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  token_start,
    input  logic                  token_end,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [1:0]            evt_kind,
    output logic [TS_BITS-1:0]    evt_time,
    output logic [DEPTH_BITS:0]   evt_count,
    output logic                  overflow,
    output logic [7:0]            drop_count
);

    localparam int unsigned DEPTH      = 1 << DEPTH_BITS;
    localparam int unsigned CNT_BITS   = DEPTH_BITS + 1;
    localparam int unsigned ENTRY_BITS = 2 + TS_BITS;

    logic [ENTRY_BITS-1:0] mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic [TS_BITS-1:0]    ts;

    logic                  push_req;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  drop;
    logic [TS_BITS-1:0]    entry_time;
    logic [ENTRY_BITS-1:0] push_entry;
    logic [DEPTH_BITS-1:0] wr_ptr_nxt;
    logic [DEPTH_BITS-1:0] rd_ptr_nxt;
    logic [CNT_BITS-1:0]   count_nxt;
    logic [ENTRY_BITS-1:0] head_nxt;
    logic [7:0]            drop_count_nxt;

`ifdef TOKEN_LOGGER_DELTA_EN
    // ts of the last accepted push; dropped events never move it
    logic [TS_BITS-1:0]    ref_ts;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ref_ts <= '0;
        end else if (push) begin
            ref_ts <= ts;
        end
    end

    always_comb begin
        entry_time = ts - ref_ts;
    end
`else
    always_comb begin
        entry_time = ts;
    end
`endif

    // Push/pop decision, next pointers, occupancy and next head entry
    always_comb begin
        push_req       = token_start | token_end;
        pop            = evt_valid & evt_ready;
        full           = (evt_count == CNT_BITS'(DEPTH));
        push           = push_req & (~full | pop);
        drop           = push_req & full & ~pop;
        push_entry     = {token_end, token_start, entry_time};
        wr_ptr_nxt     = wr_ptr;
        rd_ptr_nxt     = rd_ptr;
        count_nxt      = evt_count;
        drop_count_nxt = drop_count;
        head_nxt       = '0;

        if (push) begin
            wr_ptr_nxt = wr_ptr + DEPTH_BITS'(1);
        end
        if (pop) begin
            rd_ptr_nxt = rd_ptr + DEPTH_BITS'(1);
        end

        case ({push, pop})
            2'b10:   count_nxt = evt_count + CNT_BITS'(1);
            2'b01:   count_nxt = evt_count - CNT_BITS'(1);
            default: count_nxt = evt_count;
        endcase

        if (drop && (drop_count != 8'hFF)) begin
            drop_count_nxt = drop_count + 8'd1;
        end

        // The new head may be the entry being written this cycle (FIFO was
        // empty, or held only the entry being popped); otherwise it is in mem.
        if (count_nxt == '0) begin
            head_nxt = '0;
        end else if (push && (rd_ptr_nxt == wr_ptr)) begin
            head_nxt = push_entry;
        end else begin
            head_nxt = mem[rd_ptr_nxt];
        end
    end

    // Storage array; contents are don't-care once the pointers are cleared
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Control state and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts         <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            evt_count  <= '0;
            evt_valid  <= 1'b0;
            evt_kind   <= 2'b00;
            evt_time   <= '0;
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end else begin
            ts         <= ts + TS_BITS'(1);
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            evt_count  <= count_nxt;
            evt_valid  <= (count_nxt != '0);
            evt_kind   <= head_nxt[ENTRY_BITS-1 -: 2];
            evt_time   <= head_nxt[TS_BITS-1:0];
            overflow   <= overflow | drop;
            drop_count <= drop_count_nxt;
        end
    end

endmodule
